// File: rtl/uart_rx_cfg_if.sv
// uart_rx_cfg_if: serial input line and received-word outputs of uart_rx_cfg
interface uart_rx_cfg_if #(parameter int DATA_BITS = 8);
    logic                 i_RX_Serial;
    logic                 o_RX_DV;
    logic [DATA_BITS-1:0] o_RX_Data;
    logic                 o_Parity_Err;
    logic                 o_Frame_Err;
    logic                 o_Break;
    logic                 o_Busy;
    modport master (output i_RX_Serial, input o_RX_DV, o_RX_Data, o_Parity_Err, o_Frame_Err, o_Break, o_Busy);
    modport slave (input i_RX_Serial, output o_RX_DV, o_RX_Data, o_Parity_Err, o_Frame_Err, o_Break, o_Busy);
endinterface

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver with majority-vote sampling and parity/frame/break flags
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS = 8,
    parameter int PARITY = 0,
    parameter int STOP_BITS = 1
) (
    input logic          i_Clock,
    input logic          i_Reset,
    uart_rx_cfg_if.slave bus
);
    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0] DLAST = 4'(DATA_BITS - 1);
    localparam logic [3:0] SLAST = 4'(STOP_BITS - 1);
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, DONE, WAIT_HIGH} state_t;
    state_t state_q, state_d;
    logic [1:0] sync_q, sync_d;
    logic [2:0] hist_q, hist_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0] idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
    logic par_q, par_d, stop_err_q, stop_err_d, any_one_q, any_one_d;
    logic dv_q, dv_d, perr_q, perr_d, ferr_q, ferr_d, brk_q, brk_d;
    logic s_rx, sample, tick;
    assign s_rx = sync_q[1];
    assign sample = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
    assign tick = cnt_q == LAST;
    always_comb begin
        sync_d = {sync_q[0], bus.i_RX_Serial};
        hist_d = {hist_q[1:0], s_rx};
        state_d = state_q;
        cnt_d = tick ? '0 : cnt_q + CW'(1);
        idx_d = idx_q;
        shift_d = shift_q;
        par_d = par_q;
        stop_err_d = stop_err_q;
        any_one_d = any_one_q;
        dv_d = 1'b0;
        data_d = data_q;
        perr_d = perr_q;
        ferr_d = ferr_q;
        brk_d = brk_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                stop_err_d = 1'b0;
                any_one_d = 1'b0;
                if (!s_rx) state_d = START;
            end
            START: if (cnt_q == HALF) begin
                cnt_d = '0;
                state_d = sample ? IDLE : DATA;
            end
            DATA: if (tick) begin
                shift_d = {sample, shift_q[DATA_BITS-1:1]};
                any_one_d = any_one_q | sample;
                idx_d = idx_q + 4'd1;
                if (idx_q == DLAST) begin
                    idx_d = '0;
                    state_d = (PARITY != 0) ? PAR : STOP;
                end
            end
            PAR: if (tick) begin
                par_d = sample;
                any_one_d = any_one_q | sample;
                state_d = STOP;
            end
            STOP: if (tick) begin
                stop_err_d = stop_err_q | ~sample;
                any_one_d = any_one_q | sample;
                idx_d = idx_q + 4'd1;
                // flags are registered on entry to DONE so they are valid in the strobe cycle
                if (idx_q == SLAST) begin
                    state_d = DONE;
                    dv_d = 1'b1;
                    data_d = shift_q;
                    perr_d = (PARITY != 0) && ((^shift_q ^ par_q) != (PARITY == 2));
                    ferr_d = stop_err_d;
                    brk_d = ~any_one_d;
                end
            end
            DONE: state_d = ferr_q ? WAIT_HIGH : IDLE;
            WAIT_HIGH: if (s_rx) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q <= IDLE;
            sync_q <= 2'b11;
            hist_q <= 3'b111;
            cnt_q <= '0;
            idx_q <= '0;
            shift_q <= '0;
            par_q <= 1'b0;
            stop_err_q <= 1'b0;
            any_one_q <= 1'b0;
            dv_q <= 1'b0;
            data_q <= '0;
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
            brk_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q <= sync_d;
            hist_q <= hist_d;
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            shift_q <= shift_d;
            par_q <= par_d;
            stop_err_q <= stop_err_d;
            any_one_q <= any_one_d;
            dv_q <= dv_d;
            data_q <= data_d;
            perr_q <= perr_d;
            ferr_q <= ferr_d;
            brk_q <= brk_d;
        end
    end
    assign bus.o_RX_DV = dv_q;
    assign bus.o_RX_Data = data_q;
    assign bus.o_Parity_Err = perr_q;
    assign bus.o_Frame_Err = ferr_q;
    assign bus.o_Break = brk_q;
    assign bus.o_Busy = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: table-driven scoreboard bench over 8N1, even-parity and 7-bit/2-stop receivers
module tb_uart_rx_cfg;
    localparam int CPB = 16;
    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } exp_t;
    typedef struct {
        int inst;
        int data;
        int par;
        int stops;
        int gap;
        int rdata;
        int rperr;
        int rferr;
        int rbrk;
    } vec_t;
    logic i_Clock = 1'b0;
    logic i_Reset = 1'b1;
    int n_vec = 0;
    int n_err = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    vec_t tbl[12];
    always #5 i_Clock = ~i_Clock;
    uart_rx_cfg_if #(.DATA_BITS(8)) b0 ();
    uart_rx_cfg_if #(.DATA_BITS(8)) b1 ();
    uart_rx_cfg_if #(.DATA_BITS(7)) b2 ();
    uart_rx_cfg #(.CLKS_PER_BIT(CPB)) u0 (.i_Clock(i_Clock), .i_Reset(i_Reset), .bus(b0));
    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .PARITY(1)) u1 (.i_Clock(i_Clock), .i_Reset(i_Reset), .bus(b1));
    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(2)) u2 (.i_Clock(i_Clock), .i_Reset(i_Reset), .bus(b2));
    task automatic check(string nm, int act, int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask
    task automatic push(int inst, int d, int pe, int fe, int br);
        exp_t e;
        e.data = 9'(d);
        e.perr = 1'(pe);
        e.ferr = 1'(fe);
        e.brk = 1'(br);
        case (inst)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask
    task automatic score(int inst, logic dv, logic pdv, logic [8:0] d, logic pe, logic fe, logic br);
        exp_t e;
        int sz;
        if (!dv) return;
        check($sformatf("inst%0d_dv_single_cycle", inst), int'(pdv), 0);
        case (inst)
            0: sz = q0.size();
            1: sz = q1.size();
            default: sz = q2.size();
        endcase
        if (sz == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL inst%0d_unexpected_dv: got strobe with data %0h, required no strobe", inst, d);
            return;
        end
        case (inst)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
        check($sformatf("inst%0d_data", inst), int'(d), int'(e.data));
        check($sformatf("inst%0d_parity_err", inst), int'(pe), int'(e.perr));
        check($sformatf("inst%0d_frame_err", inst), int'(fe), int'(e.ferr));
        check($sformatf("inst%0d_break", inst), int'(br), int'(e.brk));
    endtask
    task automatic monitor();
        logic [2:0] prev;
        prev = '0;
        forever begin
            @(negedge i_Clock);
            score(0, b0.o_RX_DV, prev[0], 9'(b0.o_RX_Data), b0.o_Parity_Err, b0.o_Frame_Err, b0.o_Break);
            score(1, b1.o_RX_DV, prev[1], 9'(b1.o_RX_Data), b1.o_Parity_Err, b1.o_Frame_Err, b1.o_Break);
            score(2, b2.o_RX_DV, prev[2], 9'(b2.o_RX_Data), b2.o_Parity_Err, b2.o_Frame_Err, b2.o_Break);
            prev = {b2.o_RX_DV, b1.o_RX_DV, b0.o_RX_DV};
        end
    endtask
    task automatic set_line(int inst, logic v);
        case (inst)
            0: b0.i_RX_Serial = v;
            1: b1.i_RX_Serial = v;
            default: b2.i_RX_Serial = v;
        endcase
    endtask
    task automatic send_bit(int inst, logic v);
        set_line(inst, v);
        repeat (CPB) @(negedge i_Clock);
    endtask
    task automatic send_frame(int inst, logic [8:0] d, logic p, logic [1:0] st);
        send_bit(inst, 1'b0);
        for (int i = 0; i < ((inst == 2) ? 7 : 8); i++) send_bit(inst, d[i]);
        if (inst == 1) send_bit(inst, p);
        send_bit(inst, st[0]);
        if (inst == 2) send_bit(inst, st[1]);
    endtask
    initial begin
        int first;
        int n_dv;
        tbl[0]  = '{0, 'hFF, 0, 3, 0, 'hFF, 0, 0, 0};
        tbl[1]  = '{0, 'h00, 0, 3, 0, 'h00, 0, 0, 0};
        tbl[2]  = '{0, 'h12, 0, 0, 2, 'h12, 0, 1, 0};
        tbl[3]  = '{0, 'h81, 0, 3, 1, 'h81, 0, 0, 0};
        tbl[4]  = '{1, 'h37, 0, 3, 1, 'h37, 1, 0, 0};
        tbl[5]  = '{1, 'h37, 1, 3, 0, 'h37, 0, 0, 0};
        tbl[6]  = '{1, 'h00, 0, 3, 0, 'h00, 0, 0, 0};
        tbl[7]  = '{1, 'h80, 0, 3, 1, 'h80, 1, 0, 0};
        tbl[8]  = '{1, 'hC3, 0, 0, 2, 'hC3, 0, 1, 0};
        tbl[9]  = '{2, 'h55, 0, 1, 1, 'h55, 0, 1, 0};
        tbl[10] = '{2, 'h2A, 0, 3, 0, 'h2A, 0, 0, 0};
        tbl[11] = '{2, 'h7F, 0, 3, 1, 'h7F, 0, 0, 0};
        b0.i_RX_Serial = 1'b1;
        b1.i_RX_Serial = 1'b1;
        b2.i_RX_Serial = 1'b1;
        fork monitor(); join_none
        repeat (3) @(negedge i_Clock);
        check("reset_dv", int'(b0.o_RX_DV), 0);
        check("reset_data", int'(b0.o_RX_Data), 0);
        check("reset_flags", int'({b0.o_Parity_Err, b0.o_Frame_Err, b0.o_Break}), 0);
        check("reset_busy", int'({b0.o_Busy, b1.o_Busy, b2.o_Busy}), 0);
        i_Reset = 1'b0;
        repeat (2 * CPB) @(negedge i_Clock);
        // strobe lands at t0+153, t0 being two cycles after the pin falls
        push(0, 'hA5, 0, 0, 0);
        first = -1;
        n_dv = 0;
        fork
            begin
                send_frame(0, 9'h0A5, 1'b0, 2'b11);
                push(0, 'h3C, 0, 0, 0);
                send_frame(0, 9'h03C, 1'b0, 2'b11);
                send_bit(0, 1'b1);
            end
            begin
                for (int k = 1; k <= 170; k++) begin
                    @(negedge i_Clock);
                    if (b0.o_RX_DV) begin
                        n_dv++;
                        if (first < 0) first = k;
                    end
                end
            end
        join
        check("a5_dv_cycle", first, 155);
        check("a5_dv_count", n_dv, 1);
        set_line(0, 1'b0);
        repeat (5) @(negedge i_Clock);
        set_line(0, 1'b1);
        check("glitch_busy_seen", int'(b0.o_Busy), 1);
        for (int k = 0; k < 12 && b0.o_Busy; k++) @(negedge i_Clock);
        check("glitch_busy_clear", int'(b0.o_Busy), 0);
        repeat (2 * CPB) @(negedge i_Clock);
        push(0, 0, 0, 1, 1);
        set_line(0, 1'b0);
        repeat (12 * CPB) @(negedge i_Clock);
        check("break_busy_held", int'(b0.o_Busy), 1);
        check("break_one_strobe", q0.size(), 0);
        set_line(0, 1'b1);
        repeat (2 * CPB) @(negedge i_Clock);
        check("break_busy_clear", int'(b0.o_Busy), 0);
        for (int i = 0; i < 12; i++) begin
            push(tbl[i].inst, tbl[i].rdata, tbl[i].rperr, tbl[i].rferr, tbl[i].rbrk);
            send_frame(tbl[i].inst, 9'(tbl[i].data), 1'(tbl[i].par), 2'(tbl[i].stops));
            repeat (tbl[i].gap) send_bit(tbl[i].inst, 1'b1);
        end
        send_bit(0, 1'b0);
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        set_line(0, 1'b1);
        repeat (CPB / 2) @(negedge i_Clock);
        i_Reset = 1'b1;
        @(negedge i_Clock);
        i_Reset = 1'b0;
        check("midreset_busy", int'(b0.o_Busy), 0);
        check("midreset_data", int'(b0.o_RX_Data), 0);
        check("midreset_flags", int'({b0.o_RX_DV, b0.o_Parity_Err, b0.o_Frame_Err, b0.o_Break}), 0);
        repeat (12 * CPB) @(negedge i_Clock);
        check("midreset_idle", int'(b0.o_Busy), 0);
        push(0, 'h96, 0, 0, 0);
        send_frame(0, 9'h096, 1'b0, 2'b11);
        repeat (3 * CPB) @(negedge i_Clock);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        check("q2_drained", q2.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
